constraint_sample_sequencer: RTL
================================

# constraint_sample_sequencer

Sequencer that drives the combinational constraint checker (20 variable inputs, single `x` satisfied output) as a rejection sampler. It generates pseudo-random candidate vectors from an LFSR and presents each to the checker. It captures the checker verdict, offers every satisfying candidate on a valid/ready sample port, and stops after a requested number of accepted samples or a run of consecutive rejections. It sits between the run-control/config registers and the checker instance.

## Interface
- `NUM_VARS`, 20: number of checker variables; each gets one 32-bit candidate word.
- `CNT_W`, 16: width of sample/try counters and limits.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: run request; honoured only in IDLE, DONE or FAIL.
- `seed` in 32: LFSR seed, latched on accepted `start`; 0 is replaced by 32'h1.
- `num_samples` in CNT_W: accepted samples required; latched on `start`.
- `max_tries` in CNT_W: consecutive-rejection limit; latched on `start`; 0 means unlimited.
- `cand_o` out NUM_VARS*32: candidate vector, word i = bits [32i+31:32i], wired to checker var_i (checker truncates to its own widths).
- `sat_i` in 1: checker `x` output.
- `smp_valid` out 1: accepted sample available (data = `cand_o`).
- `smp_ready` in 1: consumer accepts sample.
- `busy` out 1: high in FILL, CHECK and OFFER.
- `done` out 1: sticky, `num_samples` accepted; cleared by next accepted `start`.
- `fail` out 1: sticky, `max_tries` consecutive rejections; cleared by next accepted `start`.
- `acc_cnt` out CNT_W: samples accepted this run.
- `try_cnt` out CNT_W: consecutive rejections since last acceptance; saturates at all-ones.

## Operation
- The LFSR is 32-bit Galois, right-shifting. Each step is `lsb = s[0]; s = s >> 1; if lsb: s ^= 32'h80200003`. It is not reseeded between candidates.
- **States:** IDLE, FILL, CHECK, OFFER, DONE, FAIL.
- **IDLE/DONE/FAIL + `start`:**
  - Latch `seed`, `num_samples` and `max_tries`.
  - Clear `acc_cnt`, `try_cnt`, `done` and `fail`.
  - If `num_samples` is 0, go to DONE. Otherwise set fill_idx=0 and go to FILL.
- **FILL:** each cycle steps the LFSR and writes the new value into word fill_idx, then fill_idx++. After word NUM_VARS-1 is written, go to CHECK.
- **CHECK:** one cycle; `cand_o` is stable and `sat_i` is sampled at the end of the cycle.
  - `sat_i`=1: go to OFFER.
  - `sat_i`=0: `try_cnt`++ (saturating). If `max_tries`≠0 and the new `try_cnt`==`max_tries`, go to FAIL; else reset fill_idx and go to FILL.
- **OFFER:**
  - `smp_valid`=1 and `cand_o` is held.
  - On `smp_valid && smp_ready`: `acc_cnt`++ and `try_cnt`=0. If the new `acc_cnt`==`num_samples`, go to DONE; else go to FILL.
- **DONE/FAIL:** `done`/`fail` stays high and `cand_o` holds its last value until the next accepted `start`.
- `start` is ignored while `busy`=1.
- `cand_o` changes only in FILL; the checker sees only fully written vectors in CHECK and OFFER.

## Timing
- **Reset values:** state=IDLE; LFSR=32'h1; `cand_o`=0; `smp_valid`, `busy`, `done`, `fail`=0; `acc_cnt`=`try_cnt`=0; latched limits=0.
- **Cycle numbering:** cycle 0 = `start` sampled in IDLE. FILL occupies cycles 1..NUM_VARS, CHECK is cycle NUM_VARS+1, and OFFER is entered at cycle NUM_VARS+2.
- **Per-attempt cost:** NUM_VARS+1 cycles. Each accepted sample adds ≥1 OFFER cycle; OFFER lasts until `smp_ready`.
- **Outputs:** `smp_valid`, `busy`, `done` and `fail` are registered state decodes. `done`/`fail` rise the cycle after the terminating handshake or check.
- **Valid/ready rules:** `smp_valid` never drops without a handshake. `smp_ready` is a don't-care outside OFFER. `smp_ready` held high costs exactly 1 OFFER cycle per sample.
- **`rst` mid-run:** immediate return to all reset values; no sample is emitted; the run must be restarted.
- **`start` in the same cycle as a terminating event:** `start` is not honoured, because the block is still busy in that cycle.

## Test plan
- **Reset/idle:** assert `rst` mid-FILL → all outputs return to reset values immediately; after release, `busy`=0 until `start`.
- **Seed 0, `sat_i`=1, `num_samples`=1, `smp_ready`=1:**
  - word0=32'h80200003, word1=32'hC0300002.
  - `smp_valid` is high at cycle 22 for exactly 1 cycle.
  - `done`=1 at cycle 23; `acc_cnt`=1.
- **`sat_i`=0, `max_tries`=5:**
  - Exactly 5 CHECK cycles, then `fail`=1 at cycle 106; `try_cnt`=5, `acc_cnt`=0.
  - `smp_valid` is never high.
- **Backpressure:** `sat_i`=1, `num_samples`=3, `smp_ready` low for 7 OFFER cycles per sample:
  - `cand_o` is stable while `smp_valid` is high.
  - 3 handshakes with distinct vectors; `done` follows the third.
- **Mixed verdicts:** `sat_i` pattern 0,0,1,0,1 with `max_tries`=3 and `num_samples`=2:
  - `try_cnt` sequence 1,2,0,1,0.
  - `done`=1 with no fail.
- **Edge limits:**
  - `num_samples`=0 → `done` the cycle after `start`, no FILL.
  - `max_tries`=0 with `sat_i`=0 for 70000 checks → no `fail`; `try_cnt` saturates at 16'hFFFF.
  - `start` pulsed during FILL → ignored.

Source files
------------

// File: rtl/constraint_sample_sequencer.sv
// Rejection-sampling sequencer: fills a candidate vector from a Galois LFSR, checks it
// against the combinational constraint checker, and offers satisfying vectors on valid/ready.
module constraint_sample_sequencer #(
    parameter int NUM_VARS = 20,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            seed,
    input  logic [CNT_W-1:0]       num_samples,
    input  logic [CNT_W-1:0]       max_tries,
    output logic [NUM_VARS*32-1:0] cand_o,
    input  logic                   sat_i,
    output logic                   smp_valid,
    input  logic                   smp_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [CNT_W-1:0]       acc_cnt,
    output logic [CNT_W-1:0]       try_cnt
);

    localparam int               IDX_W     = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VARS - 1);
    localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CHECK,
        S_OFFER,
        S_DONE,
        S_FAIL
    } state_t;

    state_t                    state, state_nxt;
    logic [31:0]               lfsr, lfsr_step;
    logic [NUM_VARS-1:0][31:0] cand;
    logic [IDX_W-1:0]          fill_idx;
    logic [CNT_W-1:0]          num_q, max_q;
    logic [CNT_W-1:0]          try_inc, acc_inc;
    logic                      start_ok;
    logic                      tries_exhausted;

    assign start_ok        = start && (state == S_IDLE || state == S_DONE || state == S_FAIL);
    assign lfsr_step       = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
    assign try_inc         = (&try_cnt) ? try_cnt : try_cnt + CNT_W'(1);
    assign acc_inc         = acc_cnt + CNT_W'(1);
    assign tries_exhausted = (max_q != '0) && (try_inc == max_q);
    assign cand_o          = cand;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first, so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_ok) state_nxt = (num_samples == '0) ? S_DONE : S_FILL;
            end
            S_FILL: begin
                if (fill_idx == LAST_IDX) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (sat_i)                state_nxt = S_OFFER;
                else if (tries_exhausted) state_nxt = S_FAIL;
                else                      state_nxt = S_FILL;
            end
            S_OFFER: begin
                if (smp_ready) state_nxt = (acc_inc == num_q) ? S_DONE : S_FILL;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        smp_valid = (state == S_OFFER);
        busy      = (state == S_FILL) || (state == S_CHECK) || (state == S_OFFER);
        done      = (state == S_DONE);
        fail      = (state == S_FAIL);
    end

    // NOTE: the candidate register bank is reset too, because cand_o must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr     <= 32'h1;
            cand     <= '0;
            fill_idx <= '0;
            num_q    <= '0;
            max_q    <= '0;
            acc_cnt  <= '0;
            try_cnt  <= '0;
        end else if (start_ok) begin
            lfsr     <= (seed == 32'h0) ? 32'h1 : seed;
            num_q    <= num_samples;
            max_q    <= max_tries;
            acc_cnt  <= '0;
            try_cnt  <= '0;
            fill_idx <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    lfsr           <= lfsr_step;
                    cand[fill_idx] <= lfsr_step;
                    fill_idx       <= fill_idx + IDX_W'(1);
                end
                S_CHECK: begin
                    fill_idx <= '0;
                    if (!sat_i) try_cnt <= try_inc;
                end
                S_OFFER: begin
                    if (smp_ready) begin
                        acc_cnt  <= acc_inc;
                        try_cnt  <= '0;
                        fill_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
